// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA-style raster timing generator.
//
// Purpose:
//   Walks a horizontal and a vertical counter over the full raster,
//   including front porch, sync and back porch. It advances one pixel
//   on each clock where pix_en is high. Every timing output is
//   registered. Each one is decoded from the next counter values, so
//   xpos/ypos and all flags describe the same pixel on the same clock.
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset (forces last pixel of frame)
//   pix_en       pixel tick; counters advance only when high
//   xpos, ypos   current column / line
//   disp_active  pixel lies in the visible area
//   hsync, vsync sync outputs, asserted level set by HS_POL / VS_POL
//   line_start   one-clock pulse when a tick moves xpos to 0
//   frame_start  one-clock pulse when a tick moves to (0,0)
//   h_resolution constant H_VISIBLE
//   v_resolution constant V_VISIBLE
module vga_sync_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pix_en,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        disp_active,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [10:0] h_resolution,
    output logic [10:0] v_resolution
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // The 11-bit counters cannot hold a larger raster.
    generate
        if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_timing
            $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds 2047");
        end
    endgenerate

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] H_SY_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SY_END = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_SY_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SY_END = 11'(V_VISIBLE + V_FP + V_SYNC);

    assign h_resolution = H_VIS;
    assign v_resolution = V_VIS;

    logic [10:0] x_nxt, y_nxt;
    logic        h_wrap;
    logic        da_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;

    // Next-state counters. The flags are decoded from these values, not
    // from the current ones, so they land in the same cycle as xpos/ypos.
    always_comb begin
        x_nxt  = xpos;
        y_nxt  = ypos;
        h_wrap = (xpos == H_LAST);
        if (pix_en) begin
            if (h_wrap) begin
                x_nxt = 11'd0;
                y_nxt = (ypos == V_LAST) ? 11'd0 : 11'(ypos + 11'd1);
            end else begin
                x_nxt = 11'(xpos + 11'd1);
            end
        end
        da_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_nxt = (x_nxt >= H_SY_BEG && x_nxt < H_SY_END) ? HS_POL : ~HS_POL;
        vs_nxt = (y_nxt >= V_SY_BEG && y_nxt < V_SY_END) ? VS_POL : ~VS_POL;
        // Pulses fire only on the tick that moves the counters, so they
        // drop to 0 on any clock where pix_en is low.
        ls_nxt = pix_en && h_wrap;
        fs_nxt = pix_en && h_wrap && (ypos == V_LAST);
    end

    // Reset parks the raster on its last pixel. The first tick after
    // release then wraps to (0,0) and raises frame_start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xpos        <= H_LAST;
            ypos        <= V_LAST;
            disp_active <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            xpos        <= x_nxt;
            ypos        <= y_nxt;
            disp_active <= da_nxt;
            hsync       <= hs_nxt;
            vsync       <= vs_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen -- bench for vga_sync_gen.
// Two instances: u0 uses the default 640x480 timing. u1 uses a small
// raster so that whole frames fit in a short run. An independent pixel
// model pushes the expected outputs for each step into a per-instance
// queue. The queue entry is popped and compared once the DUT has updated.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        da;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } exp_t;

    // Small raster for u1: 16 x 11 = 176 clocks per frame
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;

    logic clock = 1'b0;
    logic rn0, rn1, pe0, pe1;
    logic [10:0] x0, y0, hr0, vr0, x1, y1, hr1, vr1;
    logic da0, hs0, vs0, ls0, fs0, da1, hs1, vs1, ls1, fs1;

    always #5 clock = ~clock;

    vga_sync_gen u0 (
        .clock(clock), .reset_n(rn0), .pix_en(pe0),
        .xpos(x0), .ypos(y0), .disp_active(da0), .hsync(hs0), .vsync(vs0),
        .line_start(ls0), .frame_start(fs0),
        .h_resolution(hr0), .v_resolution(vr0)
    );

    vga_sync_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) u1 (
        .clock(clock), .reset_n(rn1), .pix_en(pe1),
        .xpos(x1), .ypos(y1), .disp_active(da1), .hsync(hs1), .vsync(vs1),
        .line_start(ls1), .frame_start(fs1),
        .h_resolution(hr1), .v_resolution(vr1)
    );

    int   tests = 0;
    int   fails = 0;
    int   mx[2];
    int   my[2];
    exp_t q0[$];
    exp_t q1[$];

    // Expected levels for pixel (x,y) of instance i; pulses cleared.
    function automatic exp_t decode(input int i, input int x, input int y);
        int   hv, hf, hsw, vv, vf, vsw;
        logic hp, vp;
        exp_t e;
        if (i == 0) begin
            hv = 640; hf = 16; hsw = 96; vv = 480; vf = 10; vsw = 2; hp = 1'b0; vp = 1'b0;
        end else begin
            hv = S_HV; hf = S_HF; hsw = S_HS; vv = S_VV; vf = S_VF; vsw = S_VS; hp = 1'b1; vp = 1'b0;
        end
        e.x  = 11'(x);
        e.y  = 11'(y);
        e.da = (x < hv) && (y < vv);
        e.hs = (x >= hv + hf && x < hv + hf + hsw) ? hp : ~hp;
        e.vs = (y >= vv + vf && y < vv + vf + vsw) ? vp : ~vp;
        e.ls = 1'b0;
        e.fs = 1'b0;
        return e;
    endfunction

    function automatic int htot(input int i);
        return (i == 0) ? 800 : S_HV + S_HF + S_HS + S_HB;
    endfunction

    function automatic int vtot(input int i);
        return (i == 0) ? 525 : S_VV + S_VF + S_VS + S_VB;
    endfunction

    function automatic exp_t obs(input int i);
        return (i == 0) ? {x0, y0, da0, hs0, vs0, ls0, fs0}
                        : {x1, y1, da1, hs1, vs1, ls1, fs1};
    endfunction

    task automatic push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic check(input int i, input string tag);
        exp_t e, o;
        int   n;
        n = (i == 0) ? q0.size() : q1.size();
        tests++;
        if (n == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty for u%0d", tag, i);
            return;
        end
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        o = obs(i);
        assert (o === e) else begin
            fails++;
            $error("FAIL %s u%0d: got x=%0d y=%0d da=%b hs=%b vs=%b ls=%b fs=%b, want x=%0d y=%0d da=%b hs=%b vs=%b ls=%b fs=%b",
                   tag, i, o.x, o.y, o.da, o.hs, o.vs, o.ls, o.fs,
                   e.x, e.y, e.da, e.hs, e.vs, e.ls, e.fs);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Model side of a reset: last pixel of the frame, no pulses.
    task automatic model_reset(input int i);
        mx[i] = htot(i) - 1;
        my[i] = vtot(i) - 1;
        push(i, decode(i, mx[i], my[i]));
    endtask

    // Drive pix_en for one clock on instance i, predict, compare after the edge.
    task automatic tick(input int i, input logic pe, input string tag);
        exp_t e;
        logic moved;
        if (i == 0) pe0 = pe; else pe1 = pe;
        moved = 1'b0;
        if (pe) begin
            moved = 1'b1;
            if (mx[i] == htot(i) - 1) begin
                mx[i] = 0;
                my[i] = (my[i] == vtot(i) - 1) ? 0 : my[i] + 1;
            end else begin
                mx[i] = mx[i] + 1;
            end
        end
        e    = decode(i, mx[i], my[i]);
        e.ls = moved && (mx[i] == 0);
        e.fs = moved && (mx[i] == 0) && (my[i] == 0);
        push(i, e);
        @(posedge clock);
        #1;
        check(i, tag);
    endtask

    initial begin
        int last_fs, ls_cnt, frames;
        rn0 = 1'b0; rn1 = 1'b0; pe0 = 1'b0; pe1 = 1'b0;
        @(posedge clock);
        #1;

        // reset state and constant resolution outputs
        model_reset(0); check(0, "reset_u0");
        model_reset(1); check(1, "reset_u1");
        check_int("h_res_u0", int'(hr0), 640);
        check_int("v_res_u0", int'(vr0), 480);
        check_int("h_res_u1", int'(hr1), S_HV);
        check_int("v_res_u1", int'(vr1), S_VV);

        // first tick after release wraps to (0,0) with both pulses
        rn0 = 1'b1;
        tick(0, 1'b1, "first_tick");
        tick(0, 1'b0, "pulse_drop");
        // line 0 through the wrap onto line 1
        for (int k = 0; k < 800; k++) tick(0, 1'b1, "line0");

        // walk to (100,5), freeze for 10 clocks, then step once
        while (!(mx[0] == 100 && my[0] == 5)) tick(0, 1'b1, "walk");
        for (int k = 0; k < 10; k++) tick(0, 1'b0, "hold");
        tick(0, 1'b1, "after_hold");
        for (int k = 0; k < 200; k++) tick(0, 1'($urandom_range(0, 1)), "rand_en");

        // asynchronous reset between edges, mid-frame
        while (mx[0] != 300) tick(0, 1'b1, "walk300");
        #2 rn0 = 1'b0;
        #1;
        model_reset(0); check(0, "async_reset");
        @(posedge clock);
        #1;
        model_reset(0); check(0, "reset_held");
        rn0 = 1'b1;
        tick(0, 1'b1, "restart");

        // small raster: three full frames with pix_en held high
        pe0 = 1'b0;
        rn1 = 1'b1;
        last_fs = -1; ls_cnt = 0; frames = 0;
        for (int n = 0; n < 3 * 176 + 1; n++) begin
            tick(1, 1'b1, "frame");
            if (fs1) begin
                if (last_fs >= 0) begin
                    check_int("fs_period", n - last_fs, 176);
                    check_int("ls_per_frame", ls_cnt, 11);
                    frames++;
                end
                last_fs = n;
                ls_cnt  = 0;
            end
            if (ls1) ls_cnt++;
        end
        check_int("frames_seen", frames, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
